// File: rtl/bus_arb_mux.sv
// N-channel arbitrated bus mux: picks one valid producer (fixed priority or round-robin) into a one-deep output register.
// Latency: 1 cycle from input transfer to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready is granted only when the register is empty or draining this cycle; a stall holds all state.
module bus_arb_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [N-1:0]         out_sel,
    input  logic                 out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_idx;
    logic [N-1:0]     grant;
    logic             found;
    logic [WIDTH-1:0] win_data;
    logic             load_en;
    logic             any_vld;

    // The register can accept a new word when it is empty or is being drained this cycle.
    assign load_en = ~out_valid | out_ready;
    assign any_vld = |in_valid;

    // In reset the register is forced empty, so load_en alone would grant; gate with Reset_n.
    assign in_ready = grant & {N{load_en & Reset_n}};

    // Arbitration: scan channels in priority order, first valid one wins.
    // Round-robin starts just after the last winner; fixed priority starts at channel 0.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [PW-1:0] idx;
            if (RR != 0) begin
                idx = PW'((int'(ptr) + 1 + k) % N);
            end else begin
                idx = PW'(k);
            end
            if (!found && in_valid[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // AND-OR select of the winning channel's word using the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                win_data = win_data | in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; reset leaves ptr at N-1 so channel 0 goes first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= PW'(N - 1);
        end else if (load_en) begin
            if (any_vld) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= grant;
                if (RR != 0) begin
                    ptr <= win_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Bench for bus_arb_mux: round-robin and fixed-priority instances share one stimulus stream.
// A queue-free behavioural model per instance is compared every cycle; directed literals pin the model.
// Inputs change on the falling edge; everything is sampled before the next rising edge.
module tb_bus_arb_mux;

    localparam int W = 16;
    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0]   rdy_rr, rdy_fp, sel_rr, sel_fp;
    logic           vld_rr, vld_fp;
    logic [W-1:0]   dat_rr, dat_fp;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    bus_arb_mux #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(vld_rr), .out_data(dat_rr), .out_sel(sel_rr),
        .out_ready(out_ready)
    );

    bus_arb_mux #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fp), .out_valid(vld_fp), .out_data(dat_fp), .out_sel(sel_fp),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requesting channel when scanning from 'start' with wrap; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: index 0 = round-robin instance, index 1 = fixed-priority instance.
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    logic [N-1:0] m_sel   [2];
    int           m_ptr   [2];

    initial begin
        logic [N-1:0]   v;
        logic           r;
        logic [N*W-1:0] d;
        int             g  [2];
        logic           le [2];
        logic [N-1:0]   exp_rdy, act_rdy, act_sel;
        logic           act_vld;
        logic [W-1:0]   act_dat;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = '0;
            m_ptr[m]   = N - 1;
        end
        forever begin
            @(negedge Clk);
            #3;
            v = in_valid;
            r = out_ready;
            d = in_data;
            for (int m = 0; m < 2; m++) begin
                g[m]  = pick(v, (m == 0) ? (m_ptr[m] + 1) % N : 0);
                le[m] = !m_valid[m] || r;
                exp_rdy = '0;
                if (Reset_n && le[m] && g[m] >= 0) exp_rdy[g[m]] = 1'b1;
                act_rdy = (m == 0) ? rdy_rr : rdy_fp;
                act_vld = (m == 0) ? vld_rr : vld_fp;
                act_dat = (m == 0) ? dat_rr : dat_fp;
                act_sel = (m == 0) ? sel_rr : sel_fp;
                chk($sformatf("model_in_ready[%0d]", m), 32'(act_rdy), 32'(exp_rdy));
                chk($sformatf("model_out_valid[%0d]", m), 32'(act_vld),
                    Reset_n ? 32'(m_valid[m]) : 32'h0);
                chk($sformatf("model_out_data[%0d]", m), 32'(act_dat),
                    Reset_n ? 32'(m_data[m]) : 32'h0);
                chk($sformatf("model_out_sel[%0d]", m), 32'(act_sel),
                    Reset_n ? 32'(m_sel[m]) : 32'h0);
            end
            @(posedge Clk);
            for (int m = 0; m < 2; m++) begin
                if (!Reset_n) begin
                    m_valid[m] = 1'b0;
                    m_data[m]  = '0;
                    m_sel[m]   = '0;
                    m_ptr[m]   = N - 1;
                end else if (le[m]) begin
                    if (g[m] >= 0) begin
                        m_valid[m] = 1'b1;
                        m_data[m]  = d[g[m]*W +: W];
                        m_sel[m]   = '0;
                        m_sel[m][g[m]] = 1'b1;
                        if (m == 0) m_ptr[m] = g[m];
                    end else begin
                        m_valid[m] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic r, input logic [N*W-1:0] d,
                         input logic rst_n);
        @(negedge Clk);
        Reset_n   = rst_n;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
    endtask

    typedef struct packed {
        logic [N-1:0] v;
        logic         r;
    } vec_t;

    initial begin
        logic [N*W-1:0] base, d;
        vec_t           tbl [8];
        tbl[0] = '{v: 4'b0101, r: 1'b1};
        tbl[1] = '{v: 4'b0101, r: 1'b0};
        tbl[2] = '{v: 4'b0000, r: 1'b0};
        tbl[3] = '{v: 4'b1010, r: 1'b1};
        tbl[4] = '{v: 4'b0110, r: 1'b1};
        tbl[5] = '{v: 4'b0001, r: 1'b0};
        tbl[6] = '{v: 4'b0000, r: 1'b1};
        tbl[7] = '{v: 4'b1111, r: 1'b1};
        for (int i = 0; i < N; i++) base[i*W +: W] = W'(16'h1000 + i);

        drive('0, 1'b0, base, 1'b0);
        drive('0, 1'b0, base, 1'b0);
        #4;
        chk("reset_out_valid", 32'(vld_rr), 'h0);
        chk("reset_in_ready", 32'(rdy_rr), 'h0);

        // Single requester on channel 2.
        d = base;
        d[2*W +: W] = 16'hBEEF;
        drive(4'b0100, 1'b1, d, 1'b1);
        #4;
        chk("single_in_ready_rr", 32'(rdy_rr), 'h4);
        chk("single_in_ready_fp", 32'(rdy_fp), 'h4);
        drive('0, 1'b1, d, 1'b1);
        #4;
        chk("single_out_valid", 32'(vld_rr), 'h1);
        chk("single_out_data", 32'(dat_rr), 'hBEEF);
        chk("single_out_sel", 32'(sel_rr), 'h4);
        drive('0, 1'b1, d, 1'b1);
        #4;
        chk("drain_out_valid", 32'(vld_rr), 'h0);
        chk("drain_out_data_held", 32'(dat_rr), 'hBEEF);

        // Asynchronous reset while a word is held under a stall.
        drive(4'b1111, 1'b1, base, 1'b1);
        drive(4'b1111, 1'b0, base, 1'b1);
        #1;
        chk("prereset_out_valid", 32'(vld_rr), 'h1);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_valid_rr", 32'(vld_rr), 'h0);
        chk("async_reset_data_rr", 32'(dat_rr), 'h0);
        chk("async_reset_sel_rr", 32'(sel_rr), 'h0);
        chk("async_reset_rdy_rr", 32'(rdy_rr), 'h0);
        chk("async_reset_valid_fp", 32'(vld_fp), 'h0);
        chk("async_reset_rdy_fp", 32'(rdy_fp), 'h0);

        // Release with everyone requesting: channel 0 must win first.
        drive(4'b1111, 1'b1, base, 1'b1);
        #4;
        chk("rr_first_grant", 32'(rdy_rr), 'h1);

        // Fairness vs. fixed priority under continuous full load.
        for (int k = 1; k <= 8; k++) begin
            drive(4'b1111, 1'b1, base, 1'b1);
            #4;
            chk($sformatf("rr_seq_data[%0d]", k), 32'(dat_rr), 32'h1000 + 32'((k - 1) % 4));
            chk($sformatf("rr_seq_valid[%0d]", k), 32'(vld_rr), 'h1);
            chk($sformatf("fp_seq_data[%0d]", k), 32'(dat_fp), 'h1000);
            chk($sformatf("fp_seq_sel[%0d]", k), 32'(sel_fp), 'h1);
            chk($sformatf("fp_rdy_hi[%0d]", k), 32'(rdy_fp[3:1]), 'h0);
        end

        // Backpressure: hold ch1's word while ch0 and ch3 wait.
        d = base;
        d[1*W +: W] = 16'h00AA;
        drive(4'b0010, 1'b1, d, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(4'b1001, 1'b0, d, 1'b1);
            #4;
            chk($sformatf("stall_data_rr[%0d]", k), 32'(dat_rr), 'hAA);
            chk($sformatf("stall_data_fp[%0d]", k), 32'(dat_fp), 'hAA);
            chk($sformatf("stall_rdy_rr[%0d]", k), 32'(rdy_rr), 'h0);
            chk($sformatf("stall_rdy_fp[%0d]", k), 32'(rdy_fp), 'h0);
        end
        drive(4'b1001, 1'b1, d, 1'b1);
        #4;
        chk("unstall_rdy_rr", 32'(rdy_rr), 'h8);
        chk("unstall_rdy_fp", 32'(rdy_fp), 'h1);
        drive('0, 1'b1, d, 1'b1);
        #4;
        chk("unstall_data_rr", 32'(dat_rr), 'h1003);
        chk("unstall_sel_rr", 32'(sel_rr), 'h8);
        chk("unstall_data_fp", 32'(dat_fp), 'h1000);

        // Mixed request/ready patterns, checked by the model only.
        for (int i = 0; i < 8; i++) drive(tbl[i].v, tbl[i].r, base, 1'b1);
        drive('0, 1'b1, base, 1'b1);
        drive('0, 1'b1, base, 1'b1);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised N-channel registered bus multiplexer with built-in arbitration and a valid/ready handshake on every channel. It generalises the fixed 2/3/4-input 16-bit datapath selectors. Those take an externally supplied select. This block picks the source itself, using fixed-priority or round-robin order, and presents the winner through a one-deep output register. It sits between multiple bus producers (MAR/MDR/PC/ALU-style sources) and a single shared bus consumer.

## Interface
- WIDTH, 16, data width per channel
- N, 4, number of input channels (2..16)
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

- Clk  input  1  clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- in_valid  input  N  per-channel request; bit i = channel i has data
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept; at most one bit high
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_sel  output  N  one-hot index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer on channel i occurs in a cycle where in_valid[i] & in_ready[i] is high. Output transfer occurs where out_valid & out_ready is high.
- load_en = ~out_valid | out_ready. The register is empty or is being drained this cycle.
- Arbitration is combinational over in_valid:
  - RR=0: grant the lowest-index valid channel.
  - RR=1: search starts at (ptr+1) mod N and wraps; the first valid channel wins.
- in_ready = grant one-hot & {N{load_en}}. It is all-zero when no channel is valid.
- On a clock edge with load_en and any in_valid:
  - out_data <= winner's data
  - out_sel <= grant
  - out_valid <= 1
  - RR=1 only: ptr <= winner index
- On an edge with load_en and no in_valid: out_valid <= 0. out_data and out_sel hold their last values.
- On an edge with ~load_en (full, stalled): all registers hold, and in_ready is 0.
- ptr is not updated in RR=0. A stall does not advance ptr.
- Producers must hold in_valid and in_data until transfer. The block does not require this for correctness; a dropped request is simply not granted.
- Reset (asynchronous, any time, including mid-transfer) takes effect immediately:
  - out_valid = 0, out_data = 0, out_sel = 0
  - ptr = N-1, so channel 0 has first priority after reset
  - in_ready is 0 while Reset_n is low
  - an in-flight word is discarded

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: one word per cycle when out_ready is held high.
- in_ready depends combinationally on out_ready and in_valid. There is no combinational path from in_data to any output.
- Simultaneous drain and load in the same cycle is permitted: out_valid stays 1 and data changes with no bubble.
- Reset release is synchronised externally. The first edge with Reset_n high may already load.
- Fairness (RR=1): with all N channels continuously valid and no stall, each channel is granted exactly once per N cycles in order 0,1,…,N-1,0.

## Test plan
- Reset: assert Reset_n=0 mid-stream with out_valid=1.
  - Expect out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately, with no clock edge needed.
  - After release with all valid, first grant is channel 0.
- Single channel, N=4, WIDTH=16: in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1.
  - Expect in_ready=4'b0100.
  - Next cycle out_valid=1, out_data=16'hBEEF, out_sel=4'b0100.
- Round-robin fairness, RR=1: all channels valid with data ch_i=16'h1000+i, out_ready=1, 8 cycles.
  - Output sequence is 1000,1001,1002,1003,1000,1001,1002,1003 with no bubbles.
- Fixed priority, RR=0: the same stimulus for 8 cycles.
  - Every output is 16'h1000 and out_sel=4'b0001. in_ready[3:1] stays 0 throughout.
- Backpressure: fill register with ch1=16'h00AA, hold out_ready=0 for 3 cycles while ch0 and ch3 are valid.
  - out_data stays 16'h00AA, in_ready=0, ptr is unchanged.
  - With RR=1, on out_ready=1 the next word comes from ch3, since the search starts at 2.
- Drain to empty: one word loaded, then in_valid=0 with out_ready=1.
  - Next cycle out_valid=0 while out_data retains its value.
